// File: rtl/hazard_pipe_ctrl_if.sv
// Hazard/stall interface between the pipeline datapath (master) and the pipeline sequencer (slave).
interface hazard_pipe_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       halt_req;
    logic       step;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_bubble;
    logic       ex_mem_write;
    logic       mem_wb_bubble;
    logic       halted;
    logic       mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
               mem_req, mem_ready, halt_req, step,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, halted, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
               mem_req, mem_ready, halt_req, step,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, halted, mem_timeout
    );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, branch flush, mem-wait freeze with timeout,
// and debug halt/drain/single-step. Control outputs are Mealy from state + hazard inputs.
module hazard_pipe_ctrl #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    hazard_pipe_ctrl_if.slave  hz
);
    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_HALTED = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_C   = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] drain, drain_nxt;

    logic lu_c, freeze_c, apply_run_c, apply_freeze_c;
    logic [CNT_W-1:0] timer_inc_c;
    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c, id_ex_bubble_c;
    logic ex_mem_write_c, mem_wb_bubble_c, halted_c, mem_timeout_c;

    assign lu_c = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                  ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    assign freeze_c    = hz.mem_req && !hz.mem_ready;
    assign timer_inc_c = (timer >= TIMEOUT_C) ? timer : timer + ONE_C;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            timer <= '0;
            drain <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            drain <= drain_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        drain_nxt       = drain;
        apply_run_c     = 1'b0;
        apply_freeze_c  = 1'b0;
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_write_c   = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_write_c  = 1'b1;
        mem_wb_bubble_c = 1'b0;
        halted_c        = 1'b0;
        mem_timeout_c   = 1'b0;

        case (state)
            S_RUN: begin
                if (freeze_c) begin
                    apply_freeze_c = 1'b1;
                    timer_nxt      = ONE_C;
                    state_nxt      = S_WAIT;
                end else begin
                    apply_run_c = 1'b1;
                    if (hz.halt_req) begin
                        drain_nxt = DRAIN_C;
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_WAIT: begin
                if (hz.mem_ready) begin
                    apply_run_c = 1'b1;
                    timer_nxt   = '0;
                    if (hz.halt_req) begin
                        drain_nxt = DRAIN_C;
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end else begin
                    apply_freeze_c = 1'b1;
                    timer_nxt      = timer_inc_c;
                    if (timer_inc_c >= TIMEOUT_C) state_nxt = S_ERROR;
                end
            end
            S_DRAIN: begin
                pc_write_c    = hz.ex_branch_taken;
                if_id_flush_c = 1'b1;
                if (freeze_c) begin
                    // Drain count holds while memory stalls; timeout still applies
                    apply_freeze_c = 1'b1;
                    timer_nxt      = timer_inc_c;
                    if (timer_inc_c >= TIMEOUT_C) state_nxt = S_ERROR;
                end else begin
                    timer_nxt = '0;
                    if (drain <= ONE_C) begin
                        drain_nxt = '0;
                        state_nxt = S_HALTED;
                    end else begin
                        drain_nxt = drain - ONE_C;
                    end
                end
            end
            S_HALTED: begin
                halted_c      = 1'b1;
                pc_write_c    = 1'b0;
                if_id_flush_c = 1'b1;
                if (!hz.halt_req)  state_nxt = S_RUN;
                else if (hz.step)  state_nxt = S_STEP;
            end
            S_STEP: begin
                drain_nxt = DRAIN_C;
                state_nxt = S_DRAIN;
            end
            S_ERROR: begin
                apply_freeze_c = 1'b1;
                mem_timeout_c  = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
                timer_nxt = '0;
                drain_nxt = '0;
            end
        endcase

        // Branch redirect outranks load-use stall
        if (apply_run_c) begin
            if (hz.ex_branch_taken) begin
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
                pc_write_c     = 1'b1;
            end else if (lu_c) begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
            end
        end

        if (apply_freeze_c) begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            id_ex_write_c   = 1'b0;
            ex_mem_write_c  = 1'b0;
            mem_wb_bubble_c = 1'b1;
        end

        if (!rst) begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            if_id_flush_c   = 1'b0;
            id_ex_write_c   = 1'b0;
            id_ex_bubble_c  = 1'b0;
            ex_mem_write_c  = 1'b0;
            mem_wb_bubble_c = 1'b0;
            halted_c        = 1'b0;
            mem_timeout_c   = 1'b0;
        end
    end

    assign hz.pc_write      = pc_write_c;
    assign hz.if_id_write   = if_id_write_c;
    assign hz.if_id_flush   = if_id_flush_c;
    assign hz.id_ex_write   = id_ex_write_c;
    assign hz.id_ex_bubble  = id_ex_bubble_c;
    assign hz.ex_mem_write  = ex_mem_write_c;
    assign hz.mem_wb_bubble = mem_wb_bubble_c;
    assign hz.halted        = halted_c;
    assign hz.mem_timeout   = mem_timeout_c;
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl with TIMEOUT=4, DRAIN_CYCLES=4.
module tb_hazard_pipe_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_pipe_ctrl_if hz();

    hazard_pipe_ctrl #(.TIMEOUT(4), .DRAIN_CYCLES(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    //  ex_mem_write, mem_wb_bubble, halted, mem_timeout}
    localparam logic [8:0] ZERO  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] IDLE  = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] STALL = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] BR    = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] FRZ   = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] ERR   = 9'b0_0_0_0_0_0_1_0_1;
    localparam logic [8:0] DRN   = 9'b0_1_1_1_0_1_0_0_0;
    localparam logic [8:0] DRNBR = 9'b1_1_1_1_0_1_0_0_0;
    localparam logic [8:0] DRNFZ = 9'b0_0_1_0_0_0_1_0_0;
    localparam logic [8:0] HLT   = 9'b0_1_1_1_0_1_0_1_0;

    function automatic logic [8:0] outs();
        return {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write, hz.id_ex_bubble,
                hz.ex_mem_write, hz.mem_wb_bubble, hz.halted, hz.mem_timeout};
    endfunction

    // Check outputs 1 ns after the inputs settle, then advance to the next falling edge
    task automatic cyc(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        #1;
        obs = outs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic clr();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.halt_req = 1'b0; hz.step = 1'b0;
    endtask

    task automatic set_lu();
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clr();
        set_lu();
        cyc("reset_outputs", ZERO);
        rst = 1'b1;
        clr();
        cyc("after_reset_idle", IDLE);

        // Load-use on rs, then on rt, and with r0
        set_lu();
        cyc("lu_rs_stall", STALL);
        clr();
        cyc("lu_cleared", IDLE);
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd7; hz.id_rs = 5'd3; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1;
        cyc("lu_rt_stall", STALL);
        hz.id_uses_rt = 1'b0;
        cyc("lu_rt_unused", IDLE);
        clr();
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
        cyc("lu_r0_none", IDLE);

        // Branch beats load-use
        clr(); set_lu(); hz.ex_branch_taken = 1'b1;
        cyc("branch_and_lu", BR);
        clr();

        // Three-cycle memory wait then release
        hz.mem_req = 1'b1;
        cyc("wait_frz1", FRZ);
        cyc("wait_frz2", FRZ);
        cyc("wait_frz3", FRZ);
        hz.mem_ready = 1'b1;
        cyc("wait_release", IDLE);
        clr(); set_lu();
        cyc("back_in_run", STALL);
        clr();

        // Timeout: error from the 5th freeze cycle, sticky until reset
        hz.mem_req = 1'b1;
        cyc("to_frz1", FRZ);
        cyc("to_frz2", FRZ);
        cyc("to_frz3", FRZ);
        cyc("to_frz4", FRZ);
        cyc("to_err5", ERR);
        cyc("to_err6", ERR);
        hz.mem_ready = 1'b1;
        cyc("to_err_sticky", ERR);
        rst = 1'b0;
        cyc("to_reset", ZERO);
        rst = 1'b1;
        clr();
        cyc("to_after_reset", IDLE);

        // Reset while WAIT holds timer=2; timer must restart from scratch
        hz.mem_req = 1'b1;
        cyc("rw_frz1", FRZ);
        cyc("rw_frz2", FRZ);
        rst = 1'b0;
        cyc("rw_in_reset", ZERO);
        rst = 1'b1;
        hz.mem_req = 1'b0;
        cyc("rw_released", IDLE);
        hz.mem_req = 1'b1;
        cyc("rw_frz_a", FRZ);
        cyc("rw_frz_b", FRZ);
        cyc("rw_frz_c", FRZ);
        cyc("rw_frz_d", FRZ);
        cyc("rw_err", ERR);
        rst = 1'b0;
        clr();
        cyc("rw_reset2", ZERO);
        rst = 1'b1;
        cyc("rw_idle2", IDLE);

        // Halt, drain (with a memory pause), step, resume
        hz.halt_req = 1'b1;
        cyc("halt_req_run", IDLE);
        cyc("drain1", DRN);
        hz.mem_req = 1'b1;
        cyc("drain_paused", DRNFZ);
        hz.mem_req = 1'b0;
        cyc("drain2", DRN);
        hz.ex_branch_taken = 1'b1;
        cyc("drain3_branch", DRNBR);
        hz.ex_branch_taken = 1'b0;
        cyc("drain4", DRN);
        cyc("halted1", HLT);
        hz.step = 1'b1;
        cyc("halted_step", HLT);
        hz.step = 1'b0;
        cyc("step_cycle", IDLE);
        cyc("sdrain1", DRN);
        cyc("sdrain2", DRN);
        cyc("sdrain3", DRN);
        cyc("sdrain4", DRN);
        cyc("halted2", HLT);
        hz.halt_req = 1'b0;
        cyc("halted_leave", HLT);
        cyc("resume_idle", IDLE);
        set_lu();
        cyc("resume_run_lu", STALL);
        clr();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
